// File: rtl/cpu_pkg.sv
// Shared fetch-side types and constants for the instruction fetch unit.
package cpu_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int          INSTR_WIDTH      = 32;
    localparam int          PC_INCR          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the memory request/response, decode handshake and redirect signals of the fetch unit.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    import cpu_pkg::*;

    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [XLEN-1:0]        imem_req_addr;
    logic                   imem_rsp_valid;
    logic [INSTR_WIDTH-1:0] imem_rsp_data;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instr;
    logic [XLEN-1:0]        instr_pc;
    logic                   redirect_valid;
    logic [XLEN-1:0]        redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {instr, pc} pairs; flush wins over push. Head outputs read zero when empty.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic [XLEN-1:0]        pc_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [XLEN-1:0]        pc_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0]        pc_mem    [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            instr_mem[wr_ptr_q] <= instr_i;
            pc_mem[wr_ptr_q]    <= pc_i;
        end
    end

    assign instr_o = empty_o ? '0 : instr_mem[rd_ptr_q];
    assign pc_o    = empty_o ? '0 : pc_mem[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: one outstanding word fetch at a time, buffered into a small FIFO toward decode,
// with redirect flushing both the buffer and any in-flight response.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEFAULT_RESET_PC),
    parameter int              FIFO_DEPTH = 2
) (
    input logic                clk,
    input logic                rst,
    instr_fetch_unit_if.master bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    logic             req_valid, push, pop;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        push      = 1'b0;
        req_valid = 1'b0;
        unique case (state_q)
            REQ: begin
                req_valid = !rst && !bus.redirect_valid && (fifo_count < CNT_W'(FIFO_DEPTH));
                if (req_valid && bus.imem_req_ready) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(PC_INCR);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    push    = !bus.redirect_valid;
                    state_d = REQ;
                end else if (bus.redirect_valid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.imem_rsp_valid) state_d = REQ;
            end
            default: state_d = REQ;
        endcase
        // Redirect overrides any increment taken above; the REQ request is already suppressed.
        if (bus.redirect_valid) pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        req_pc_q <= req_pc_d;
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.instr_valid    = !fifo_empty;
    assign pop                = !fifo_empty && bus.instr_ready;

    fetch_fifo #(
        .XLEN  (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push && !fifo_full),
        .pop_i   (pop),
        .flush_i (bus.redirect_valid),
        .instr_i (bus.imem_rsp_data),
        .pc_i    (req_pc_q),
        .instr_o (bus.instr),
        .pc_o    (bus.instr_pc),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run against a stream-level model.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst2;

    instr_fetch_unit_if #(.XLEN(32)) bus ();
    instr_fetch_unit_if #(.XLEN(32)) bus2 ();

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    int checks   = 0;
    int failures = 0;

    // Memory model and delivered-stream model state.
    bit          out_busy;
    int          out_cnt;
    logic [31:0] out_addr;
    int          lat_min = 1, lat_max = 1;
    bit          mem_rand = 0;
    bit          mem_ready = 1;
    bit          inject_rsp = 0;
    logic [31:0] exp_pc;
    bit          after_redir;
    int          req_cnt;
    logic [31:0] last_req_addr;
    logic [31:0] req_q[$];
    logic [31:0] pop_pc_q[$];
    logic [31:0] pop_ins_q[$];
    int          total_pops;
    int          cyc;
    int          first_req_cyc, first_vld_cyc;
    bit          cur_req_valid;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a | 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        req_q.delete();
        pop_pc_q.delete();
        pop_ins_q.delete();
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (n) begin
            @(negedge clk);
            #1;
            check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
            check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
            check("rst_instr", bus.instr, 32'd0);
            check("rst_instr_pc", bus.instr_pc, 32'd0);
        end
        rst = 1'b0;
        out_busy = 0;
        exp_pc = 32'h0;
        after_redir = 0;
        req_cnt = 0;
        cyc = 0;
        first_req_cyc = -1;
        first_vld_cyc = -1;
        clear_logs();
    endtask

    task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt);
        logic rsp_now;
        @(negedge clk);
        cyc++;
        rsp_now = 1'b0;
        if (out_busy) begin
            if (out_cnt == 0) rsp_now = 1'b1;
            else out_cnt--;
        end
        bus.imem_rsp_valid = rsp_now || inject_rsp;
        bus.imem_rsp_data  = rsp_now ? mem_data(out_addr) : 32'hDEAD_BEEF;
        bus.imem_req_ready = mem_rand ? ($urandom_range(0, 2) != 0) : mem_ready;
        bus.instr_ready    = rdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = tgt;
        #1;
        cur_req_valid = bus.imem_req_valid;
        if (after_redir) check("vld_after_redirect", 32'(bus.instr_valid), 32'd0);
        if (redir) check("req_in_redirect", 32'(bus.imem_req_valid), 32'd0);
        if (bus.instr_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (bus.imem_req_valid) begin
            check("one_outstanding", 32'(out_busy), 32'd0);
            check("req_addr_align", 32'(bus.imem_req_addr[1:0]), 32'd0);
        end
        if (rsp_now) out_busy = 0;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            req_cnt++;
            last_req_addr = bus.imem_req_addr;
            req_q.push_back(bus.imem_req_addr);
            if (first_req_cyc < 0) first_req_cyc = cyc;
            out_busy = 1;
            out_addr = bus.imem_req_addr;
            out_cnt  = $urandom_range(lat_min, lat_max) - 1;
        end
        if (bus.instr_valid && rdy) begin
            check("instr_pc", bus.instr_pc, exp_pc);
            check("instr", bus.instr, mem_data(exp_pc));
            pop_pc_q.push_back(bus.instr_pc);
            pop_ins_q.push_back(bus.instr);
            total_pops++;
            exp_pc = exp_pc + 32'd4;
        end
        if (redir) exp_pc = {tgt[31:2], 2'b00};
        after_redir = redir;
        inject_rsp  = 0;
    endtask

    initial begin
        int rc;
        rst = 1'b1;
        rst2 = 1'b1;
        bus2.imem_req_ready = 1'b0;
        bus2.imem_rsp_valid = 1'b0;
        bus2.imem_rsp_data  = '0;
        bus2.instr_ready    = 1'b0;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;
        total_pops = 0;

        // Streaming with 1-cycle memory: pcs 0,4,8 and 2-cycle request-to-valid latency.
        do_reset(2);
        mem_ready = 1; lat_min = 1; lat_max = 1;
        repeat (8) step(1'b1, 1'b0, 32'h0);
        check("first_latency", 32'(first_vld_cyc - first_req_cyc), 32'd2);
        check("seq_pc0", pop_pc_q[0], 32'h0);
        check("seq_pc1", pop_pc_q[1], 32'h4);
        check("seq_pc2", pop_pc_q[2], 32'h8);
        check("seq_ins0", pop_ins_q[0], 32'h13);
        check("seq_ins1", pop_ins_q[1], 32'h17);
        check("seq_ins2", pop_ins_q[2], 32'h1B);

        // Backpressure: FIFO fills with exactly two requests, then fetching stops.
        do_reset(1);
        repeat (10) step(1'b0, 1'b0, 32'h0);
        check("bp_req_count", 32'(req_cnt), 32'd2);
        check("bp_req_stalled", 32'(cur_req_valid), 32'd0);
        repeat (8) step(1'b1, 1'b0, 32'h0);
        check("bp_pop0", pop_pc_q[0], 32'h0);
        check("bp_pop1", pop_pc_q[1], 32'h4);
        check("bp_resume_addr", req_q[2], 32'h8);

        // Redirect during WAIT with a late response: it must be drained and dropped.
        do_reset(1);
        lat_min = 4; lat_max = 4;
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h103);
        clear_logs();
        rc = req_cnt;
        repeat (3) step(1'b1, 1'b0, 32'h0);
        check("drain_no_req", 32'(req_cnt), 32'(rc));
        lat_min = 1; lat_max = 1;
        step(1'b1, 1'b0, 32'h0);
        check("drain_next_req", last_req_addr, 32'h100);
        repeat (4) step(1'b1, 1'b0, 32'h0);
        check("drain_first_pc", pop_pc_q[0], 32'h100);
        check("drain_first_ins", pop_ins_q[0], 32'h113);

        // Redirect coinciding with the response.
        do_reset(1);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h103);
        clear_logs();
        rc = req_cnt;
        step(1'b1, 1'b0, 32'h0);
        check("samecyc_fifo_empty", 32'(bus.instr_valid), 32'd0);
        check("samecyc_req_count", 32'(req_cnt), 32'(rc + 1));
        check("samecyc_req_addr", last_req_addr, 32'h100);
        repeat (4) step(1'b1, 1'b0, 32'h0);
        check("samecyc_first_pc", pop_pc_q[0], 32'h100);

        // Reset while WAIT with one buffered entry; a stale response afterwards is ignored.
        do_reset(1);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        lat_min = 20; lat_max = 20;
        step(1'b0, 1'b0, 32'h0);
        check("midrst_entry", 32'(bus.instr_valid), 32'd1);
        do_reset(2);
        lat_min = 1; lat_max = 1;
        mem_ready = 0;
        inject_rsp = 1;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check("midrst_late_ignored", 32'(bus.instr_valid), 32'd0);
        mem_ready = 1;
        step(1'b0, 1'b0, 32'h0);
        check("midrst_req_count", 32'(req_cnt), 32'd1);
        check("midrst_req_addr", last_req_addr, 32'h0);

        // Randomized traffic: backpressure, variable latency, frequent redirects.
        do_reset(1);
        mem_rand = 1; lat_min = 1; lat_max = 4;
        total_pops = 0;
        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, $urandom);
        end
        mem_rand = 0;
        check("rand_progress", 32'(total_pops >= 150), 32'd1);

        // PC wrap from the top of the address space.
        @(negedge clk);
        rst2 = 1'b0;
        bus2.imem_req_ready = 1'b1;
        #1;
        check("wrap_req0_valid", 32'(bus2.imem_req_valid), 32'd1);
        check("wrap_req0_addr", bus2.imem_req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        bus2.imem_rsp_valid = 1'b1;
        bus2.imem_rsp_data  = INSTR_NOP;
        #1;
        check("wrap_wait_no_req", 32'(bus2.imem_req_valid), 32'd0);
        @(negedge clk);
        bus2.imem_rsp_valid = 1'b0;
        #1;
        check("wrap_req1_valid", 32'(bus2.imem_req_valid), 32'd1);
        check("wrap_req1_addr", bus2.imem_req_addr, 32'h0000_0000);
        check("wrap_head_pc", bus2.instr_pc, 32'hFFFF_FFFC);
        check("wrap_head_ins", bus2.instr, INSTR_NOP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
